// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode definitions
// Purpose: opcode width, legal opcode constants, sequencer state encoding and
//          the legality check used by both the ALU and its request sequencer.
// Ports:   none (package).
package alu_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] OP_ADD = 4'd1;
  localparam logic [CODE_W-1:0] OP_SUB = 4'd2;
  localparam logic [CODE_W-1:0] OP_SHL = 4'd3;
  localparam logic [CODE_W-1:0] OP_SHR = 4'd4;
  localparam logic [CODE_W-1:0] OP_AND = 4'd5;
  localparam logic [CODE_W-1:0] OP_OR  = 4'd6;
  localparam logic [CODE_W-1:0] OP_NOT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [CODE_W-1:0] code);
    return (code >= OP_ADD) && (code <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - synchronous request FIFO for the ALU sequencer
// Purpose: DEPTH-entry first-word-fall-through FIFO; rdata_o shows the head.
// Ports:   clk_i/rst_i       clock, synchronous active-high reset
//          push_i/wdata_i    write strobe and data (ignored when full)
//          pop_i/rdata_o     read strobe (ignored when empty) and head data
//          full_o/empty_o    occupancy flags
//          count_o           number of stored entries
module alu_req_fifo #(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request FIFO, opcode screening and response capture for one ALU
// Purpose: buffers ALU requests, presents legal ones to the ALU for one settle
//          cycle, captures the result and returns it on a valid/ready channel.
//          Illegal opcodes never reach the ALU; they are answered with an error.
// Ports:   clk/rst                          clock, synchronous active-high reset
//          req_valid/req_ready              request handshake
//          req_code/req_a/req_b             request opcode and operands
//          rsp_valid/rsp_ready              response handshake
//          rsp_ans/rsp_err                  captured result, illegal-opcode flag
//          alu_code/alu_a/alu_b/alu_ans     ALU drive and result
//          busy                             FSM active or FIFO non-empty
//          err_count                        saturating illegal-request count
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int OP_W  = 1,
  parameter int RES_W = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_ans,
  output logic              rsp_err,
  output logic [CODE_W-1:0] alu_code,
  output logic [OP_W-1:0]   alu_a,
  output logic [OP_W-1:0]   alu_b,
  input  logic [RES_W-1:0]  alu_ans,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int ENT_W = CODE_W + 2 * OP_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [CODE_W-1:0] alu_code_q, alu_code_d;
  logic [OP_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [RES_W-1:0]  rsp_ans_q, rsp_ans_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic [ENT_W-1:0]  head;
  logic [CODE_W-1:0] head_code;
  logic [OP_W-1:0]   head_a, head_b;
  logic              fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]  fifo_count;

  alu_req_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_valid),
    .wdata_i ({req_code, req_a, req_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_code = head[ENT_W-1 -: CODE_W];
  assign head_a    = head[2*OP_W-1 -: OP_W];
  assign head_b    = head[OP_W-1:0];

  // Popping only from IDLE keeps pops out of any response-handshake cycle.
  assign pop = (state_q == ST_IDLE) && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    alu_code_d  = alu_code_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_ans_d   = rsp_ans_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_legal_op(head_code)) begin
            alu_code_d = head_code;
            alu_a_d    = head_a;
            alu_b_d    = head_b;
            state_d    = ST_SETTLE;
          end else begin
            // ALU keeps its last legal inputs; the answer is synthesised here.
            rsp_ans_d = '0;
            rsp_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETTLE: begin
        rsp_ans_d = alu_ans;
        rsp_err_d = 1'b0;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_code_q  <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_ans_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_code_q  <= alu_code_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_ans_q   <= rsp_ans_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready = !fifo_full;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_ans   = rsp_ans_q;
  assign rsp_err   = rsp_err_q;
  assign alu_code  = alu_code_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-side initiator for the combinational ALU. It buffers operation requests in a small FIFO, drives the ALU's operand and opcode inputs, captures the result and returns it over a valid/ready response channel. It screens out illegal opcodes so that the ALU only ever sees legal codes 1–7. It sits between a command source (a test controller or microsequencer) and one ALU instance.

## Interface
- `OP_W`, 1: operand width; matches the ALU `a`/`b` inputs.
- `RES_W`, 4: result width; matches the ALU `ans` output.
- `DEPTH`, 4: request FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; equals `!full`.
- `req_code` in 4: opcode.
- `req_a`, `req_b` in `OP_W`: operands.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_ans` out `RES_W`: captured result.
- `rsp_err` out 1: request had an illegal opcode.
- `alu_code` out 4: drives the ALU `code` input.
- `alu_a`, `alu_b` out `OP_W`: drive the ALU operands.
- `alu_ans` in `RES_W`: ALU result.
- `busy` out 1: `state != IDLE || count != 0`.
- `err_count` out 8: count of illegal requests, saturating.

## Operation
- Legal opcodes: 1 add, 2 sub, 3 shl, 4 shr, 5 logical and, 6 logical or, 7 not. Codes 0 and 8–15 are illegal.
- Push: a request is written to the FIFO on a cycle with `req_valid && req_ready`. A push into a full FIFO cannot occur, because `req_ready` is low whenever the FIFO is full, including on a cycle that also pops.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE, FIFO non-empty, legal head: pop the head. Load `alu_code`/`alu_a`/`alu_b` from it. Go to SETTLE.
  - IDLE, FIFO non-empty, illegal head: pop the head. Leave the `alu_*` registers unchanged. Set `rsp_ans=0`, `rsp_err=1`. Increment `err_count`, saturating at 255. Go to RESP.
  - SETTLE: register `alu_ans` into `rsp_ans` and set `rsp_err=0`. Go to RESP.
  - RESP: hold `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- While `rsp_valid` is high, `rsp_ans` and `rsp_err` stay stable until the handshake completes.
- The `alu_*` registers hold their last legal value while the block is idle, so the ALU never sees code 0.
- The result is captured verbatim. This block does no width conversion or arithmetic.
- Reset values:
  - State IDLE; FIFO empty.
  - `req_ready=1`, `rsp_valid=0`, `rsp_ans=0`, `rsp_err=0`.
  - `alu_code=1`, `alu_a=0`, `alu_b=0`.
  - `err_count=0`, `busy=0`.
- Reset mid-operation discards FIFO contents and any in-flight or unconsumed response. No partial response is emitted afterwards.

## Timing
- Legal request, FIFO empty, FSM IDLE, accepted at edge E0:
  - pop and `alu_*` update at E1;
  - `alu_ans` sampled at E2;
  - `rsp_valid` high from E2 to the handshake edge.
  - Latency is therefore 2 cycles from acceptance to `rsp_valid`.
- Illegal request under the same conditions: `rsp_valid` goes high after E1 (1 cycle).
- Minimum spacing between response handshakes is 3 cycles for legal operations and 2 cycles for illegal ones. The block never pops in the same cycle as a response handshake.
- The ALU path has one full cycle (the SETTLE cycle) between the `alu_*` register update and the `alu_ans` capture.
- `req_ready` is a registered `!full` (count < DEPTH). It reasserts the cycle after a pop.

## Structure
- Shared package `alu_pkg` holds:
  - `CODE_W=4`;
  - opcode constants `OP_ADD`..`OP_NOT` (1..7);
  - function `is_legal_op(code)`.
  - The ALU and this block both use the package.
- Sub-module `alu_req_fifo`: synchronous FIFO of width `4+2*OP_W` and depth `DEPTH`, with `full`, `empty` and `count` outputs.
- The FSM, `alu_*` registers, response registers and error counter live in the top level.

## Test plan
- Add: `code=1, a=1, b=1`, real ALU attached, `rsp_ready=1` → `rsp_valid` 2 cycles after acceptance, `rsp_ans=4'd2`, `rsp_err=0`.
- Sub: `code=2, a=0, b=1` → `rsp_ans=4'hF`. Then `code=9` → `rsp_valid` 1 cycle after pop, `rsp_ans=0`, `rsp_err=1`, `err_count=1`, and `alu_code` stays 2 throughout.
- Backpressure: hold `rsp_ready=0` and push 6 requests:
  - the first reaches RESP and 4 fill the FIFO, so `req_ready=0` at the 6th;
  - `rsp_ans` stays stable;
  - release `rsp_ready` and all 5 responses arrive in order with correct values.
- Saturation: 260 illegal requests → `err_count=255`, and the ALU code never leaves 1–7.
- Reset mid-operation: assert `rst` in SETTLE with 3 requests queued → next cycle `rsp_valid=0`, `busy=0`, `req_ready=1`, `alu_code=1`, and no response appears afterwards.
